// File: rtl/pipe_uart_tx.sv
// -----------------------------------------------------------------------------
// pipe_uart_tx
// Serial 8N1 / 8N2 transmitter fed by a valid/ready byte stream. A one-byte
// holding register accepts the next byte while the current frame shifts out,
// so a continuously valid stream produces back-to-back frames with no gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
// Ports
//   clk_48mhz  in   system clock
//   reset_n    in   asynchronous active-low reset
//   in_data    in   byte to send, sampled on an in_valid && in_ready edge
//   in_valid   in   in_data is valid
//   in_ready   out  holding register is free (pure flop output)
//   tx         out  serial line, idles high, registered
//   busy       out  a frame is shifting or a byte is held
// -----------------------------------------------------------------------------
module pipe_uart_tx #(
  parameter int CLKS_PER_BIT = 417,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q,     state_d;
  logic [7:0]      shift_q,     shift_d;
  logic [2:0]      bit_idx_q,   bit_idx_d;
  logic [BW-1:0]   baud_cnt_q,  baud_cnt_d;
  logic            stop_idx_q,  stop_idx_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            hold_valid_q, hold_valid_d;
  logic            tx_q,        tx_d;

  logic hs;
  logic baud_last;

  // Handshake: ready is simply "hold register empty".
  assign hs        = in_valid && !hold_valid_q;
  assign baud_last = (baud_cnt_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    baud_cnt_d   = baud_cnt_q;
    stop_idx_d   = stop_idx_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        if (hold_valid_q) begin
          // Defensive: a held byte should never linger in IDLE.
          shift_d      = hold_data_q;
          hold_valid_d = 1'b0;
          state_d      = START;
        end else if (hs) begin
          shift_d = in_data;
          state_d = START;
        end
      end

      START: begin
        if (hs) begin
          hold_data_d  = in_data;
          hold_valid_d = 1'b1;
        end
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end

      DATA: begin
        if (hs) begin
          hold_data_d  = in_data;
          hold_valid_d = 1'b1;
        end
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            state_d    = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            // Last stop cycle: chain straight into the next frame if a byte
            // is waiting in the hold register or arriving right now.
            stop_idx_d = 1'b0;
            bit_idx_d  = '0;
            if (hold_valid_q) begin
              shift_d      = hold_data_q;
              hold_valid_d = 1'b0;
              state_d      = START;
            end else if (hs) begin
              shift_d = in_data;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
            if (hs) begin
              hold_data_d  = in_data;
              hold_valid_d = 1'b1;
            end
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
          if (hs) begin
            hold_data_d  = in_data;
            hold_valid_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // tx follows the next state so the start bit appears on the same edge
    // the FSM leaves IDLE.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      baud_cnt_q   <= '0;
      stop_idx_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      baud_cnt_q   <= baud_cnt_d;
      stop_idx_q   <= stop_idx_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
    end
  end

  assign in_ready = !hold_valid_q;
  assign busy     = (state_q != IDLE) || hold_valid_q;
  assign tx       = tx_q;

endmodule
